uart_rx_fifo: RTL
=================

# uart_rx_fifo

Byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver flags as ready, acknowledges it with a clear pulse, and stores it in a synchronous FIFO. Bytes are presented to the consuming logic (command parser or loopback transmitter path) on a valid/ready stream. It absorbs bursts of back-to-back frames and records overruns instead of silently losing data.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `WIDTH`, 8: data width; matches receiver `data_out`.
- `CNT_W`, $clog2(DEPTH)+1: width of `count`.

- `clk`  in  1: single system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_ready`  in  1: receiver has a complete byte; level, held until cleared.
- `rx_data`  in  WIDTH: receiver byte; stable while `rx_ready`=1.
- `rx_ready_clr`  out  1: active-high acknowledge to receiver.
- `m_valid`  out  1: head byte available (= not empty).
- `m_data`  out  WIDTH: head byte, first-word-fall-through.
- `m_ready`  in  1: consumer accepts head byte.
- `count`  out  CNT_W: occupancy, 0..DEPTH.
- `full`  out  1: `count`==DEPTH.
- `overrun`  out  1: sticky; a byte was dropped.
- `ovr_clr`  in  1: clears `overrun` and `drop_cnt`.
- `drop_cnt`  out  8: dropped bytes, saturates at 255.

## Operation
- Capture FSM:
  - **S_IDLE**: on `rx_ready`=1, issue a push of `rx_data` this cycle and go to S_ACK.
  - **S_ACK**: `rx_ready_clr`=1. Stay while `rx_ready`=1. On `rx_ready`=0, return to S_IDLE.
  - Exactly one push per receiver `rx_ready` assertion.
- Push acceptance: accepted if `count`<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped: `overrun`←1, `drop_cnt`←min(`drop_cnt`+1, 255). The FSM still acknowledges the receiver.
- Pop: occurs when `m_valid`=1 and `m_ready`=1. `rd_ptr` advances. `m_ready` while empty is ignored.
- Pointers: `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap naturally at DEPTH.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- `ovr_clr` and a drop in the same cycle: the set wins (`overrun`=1, `drop_cnt`=1).
- `m_data` = `mem[rd_ptr]`. When empty its value is don't-care, but it must not be X after reset (memory is not reset; the bench masks on `m_valid`).

## Timing
- Reset values: state S_IDLE, `rx_ready_clr`=0, `m_valid`=0, `count`=0, `full`=0, `overrun`=0, `drop_cnt`=0, pointers 0.
- Reset mid-operation discards all stored bytes and any byte in capture. If `rx_ready` is still high after reset, the byte is captured again (receiver-held level).
- Latency: `rx_ready` sampled high at edge N → write at edge N → `m_valid`=1 and `rx_ready_clr`=1 from cycle N+1.
- Acknowledge: `rx_ready_clr` stays high until the cycle after `rx_ready` is sampled low. Minimum pulse is one cycle.
- Pop: at edge M with `m_valid`&&`m_ready`, the next head appears on `m_data` at cycle M+1. Sustained one byte per cycle is supported.
- Full: a push coinciding with a pop while full is accepted; `count` stays DEPTH, and the head advances.
- All outputs are registered except `m_valid`, `full` and `m_data`, which decode from registered state.

## Structure
- `uart_pkg` holds:
  - `BYTE_W`=8
  - `typedef enum logic [0:0] {S_IDLE, S_ACK} rx_cap_state_t`
  - `DROP_CNT_W`=8
- Sub-module `uart_sync_fifo` (parameters DEPTH, WIDTH): memory, pointers, count, push/pop/full/empty logic.
- `uart_rx_fifo` wraps it with the capture FSM and the overrun/drop logic.

## Test plan
- **Single byte:** receiver delivers 8'hAC with `m_ready`=0. Required: `rx_ready_clr` high from cycle N+1, `m_valid`=1, `m_data`=8'hAC, `count`=1. Then pulse `m_ready` for one cycle → `m_valid`=0, `count`=0.
- **Order and wrap:** 40 bytes, 8'h00..8'h27, with random `m_ready`, DEPTH=16. Required: output sequence identical and in order, no overrun, pointers wrap twice.
- **Overrun:** 18 bytes with `m_ready`=0. Required: `count`=16, `full`=1, `overrun`=1, `drop_cnt`=2, and the head is still byte 0. Then `ovr_clr` → `overrun`=0, `drop_cnt`=0.
- **Simultaneous push/pop at full:** when full, push byte 8'h55 in the same cycle `m_ready`=1. Required: `count` stays 16, the byte is accepted, no drop, and 8'h55 emerges 16th.
- **Reset mid-fill:** 5 bytes stored, then `rst`=1 for one cycle while `rx_ready`=0. Required: all outputs at reset values, and the next byte 8'h2B is the first one out.
- **Ack handshake:** hold `rx_ready` high for 7 cycles. Required: exactly one push, `rx_ready_clr` high for 7 cycles, and FSM back in S_IDLE one cycle after `rx_ready` falls.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and capture-FSM state type for the UART receive byte buffer.
package uart_pkg;

  localparam int BYTE_W     = 8;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } rx_cap_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only when a pop frees the head slot in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = BYTE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_req,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       push_drop
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status decode, push/pop qualification and next-state for pointers and count.
  always_comb begin
    empty     = (count_q == CNT_W'(0));
    full      = (count_q == CNT_W'(DEPTH));
    pop_ok_s  = pop_req && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    push_drop = push && !push_ok_s;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head is forced to zero when empty so the unreset memory never leaks X.
    if (empty) begin
      rd_data = {WIDTH{1'b0}};
    end else begin
      rd_data = mem_q[rd_ptr_q];
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receiver-side byte buffer: acknowledges each ready byte once, queues it,
// and counts bytes lost to a full FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = BYTE_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_ready,
  input  logic [WIDTH-1:0]      rx_data,
  output logic                  rx_ready_clr,
  output logic                  m_valid,
  output logic [WIDTH-1:0]      m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  rx_cap_state_t           state_q, state_d;
  logic                    rx_ready_clr_q, rx_ready_clr_d;
  logic                    overrun_q, overrun_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                    push_s;
  logic                    push_drop_s;
  logic                    empty_s;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (rx_data),
    .pop_req   (m_ready),
    .rd_data   (m_data),
    .empty     (empty_s),
    .full      (full),
    .count     (count),
    .push_drop (push_drop_s)
  );

  // Capture FSM: one push per rx_ready level, acknowledge held until it drops.
  always_comb begin
    state_d = state_q;
    push_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          push_s  = 1'b1;
          state_d = S_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (rx_ready) begin
          state_d = S_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rx_ready_clr_d = (state_d == S_ACK);
  end

  // Overrun flag and saturating drop counter; a drop outranks a clear.
  always_comb begin
    if (push_drop_s) begin
      overrun_d = 1'b1;
      if (ovr_clr) begin
        drop_cnt_d = DROP_CNT_W'(1);
      end else if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (ovr_clr) begin
      overrun_d  = 1'b0;
      drop_cnt_d = DROP_CNT_W'(0);
    end else begin
      overrun_d  = overrun_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rx_ready_clr_q <= 1'b0;
      overrun_q      <= 1'b0;
      drop_cnt_q     <= DROP_CNT_W'(0);
    end else begin
      state_q        <= state_d;
      rx_ready_clr_q <= rx_ready_clr_d;
      overrun_q      <= overrun_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign m_valid      = !empty_s;
  assign rx_ready_clr = rx_ready_clr_q;
  assign overrun      = overrun_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
